// File: rtl/tx_message_driver.sv
// Streams the fixed "Hello, World!" message into a UART transmitter, paced on TxEmpty.
// Define TXDRIVER_REPEAT_EN to loop the message forever instead of halting after '!'.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | after reset, waiting for the transmitter to become ready
//   SEND  | XMitGo high, TxData valid, waiting for TxEmpty to fall
//   WAIT  | byte accepted, waiting for TxEmpty to rise again
//   DONE  | whole message sent, parked until reset
module tx_message_driver #(
    parameter int MSG_LEN = 13,
    parameter int DATA_W  = 8
) (
    input  logic              Enable,
    input  logic              Reset,
    input  logic              TxEmpty,
    output logic              XMitGo,
    output logic [DATA_W-1:0] TxData
);

    localparam int AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(MSG_LEN - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_nx;
    logic [AW-1:0]     address;
    logic [AW-1:0]     address_nx;
    logic [DATA_W-1:0] txdata_nx;

    function automatic logic [DATA_W-1:0] rom(input logic [AW-1:0] a);
        logic [7:0] c;
        case (a)
            AW'(0):  c = 8'h48;
            AW'(1):  c = 8'h65;
            AW'(2):  c = 8'h6C;
            AW'(3):  c = 8'h6C;
            AW'(4):  c = 8'h6F;
            AW'(5):  c = 8'h2C;
            AW'(6):  c = 8'h20;
            AW'(7):  c = 8'h57;
            AW'(8):  c = 8'h6F;
            AW'(9):  c = 8'h72;
            AW'(10): c = 8'h6C;
            AW'(11): c = 8'h64;
            AW'(12): c = 8'h21;
            default: c = 8'h00;
        endcase
        return DATA_W'(c);
    endfunction

    // TxData is only ever loaded on a transition into SEND, so it is frozen while XMitGo is high.
    always_comb begin
        state_nx   = state;
        address_nx = address;
        txdata_nx  = TxData;
        case (state)
            IDLE: begin
                if (TxEmpty) begin
                    state_nx  = SEND;
                    txdata_nx = rom(address);
                end
            end
            SEND: begin
                if (!TxEmpty) state_nx = WAIT;
            end
            WAIT: begin
                if (TxEmpty) begin
                    if (address == LAST_ADDR) begin
`ifdef TXDRIVER_REPEAT_EN
                        address_nx = '0;
                        txdata_nx  = rom('0);
                        state_nx   = SEND;
`else
                        state_nx   = DONE;
`endif
                    end else begin
                        address_nx = address + AW'(1);
                        txdata_nx  = rom(address + AW'(1));
                        state_nx   = SEND;
                    end
                end
            end
            DONE: ;
            default: state_nx = IDLE;
        endcase
    end

    // XMitGo is decoded from the next state so it leaves the flop with no path from TxEmpty.
    always_ff @(posedge Enable or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            address <= '0;
            XMitGo  <= 1'b0;
            TxData  <= '0;
        end else begin
            state   <= state_nx;
            address <= address_nx;
            XMitGo  <= (state_nx == SEND);
            TxData  <= txdata_nx;
        end
    end

endmodule

// File: tb/tb_tx_message_driver.sv
// Bench for tx_message_driver: a behavioural UART transmitter with random accept/busy delays
// and a string-based expectation of the byte stream.
module tb_tx_message_driver;

    logic       Enable = 1'b0;
    logic       Reset  = 1'b0;
    logic       TxEmpty = 1'b1;
    logic       XMitGo;
    logic [7:0] TxData;

    tx_message_driver #(.MSG_LEN(13), .DATA_W(8)) dut (
        .Enable (Enable),
        .Reset  (Reset),
        .TxEmpty(TxEmpty),
        .XMitGo (XMitGo),
        .TxData (TxData)
    );

    always #5 Enable = ~Enable;

    string msg = "Hello, World!";

    int n_cmp = 0;
    int n_err = 0;

    // transmitter model and monitor state
    int         txs;
    int         dcnt;
    int         bcnt;
    int         cyc;
    int         last_rise;
    int         exp_idx;
    int         nrx;
    logic       prev_go;
    logic [7:0] held;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: sample the DUT at the falling edge, then update the transmitter model.
    task automatic step(input int min_d, input int max_d, input int max_b, input bit ideal);
        logic te_prev;
        @(negedge Enable);
        cyc++;
        te_prev = TxEmpty;
        if (prev_go) check("go_hold", XMitGo, te_prev);
        if (XMitGo && !prev_go) begin
            check("byte", TxData, msg[exp_idx % 13]);
            if (ideal) check("gap", cyc - last_rise, (nrx == 0) ? 1 : 2);
            last_rise = cyc;
            held = TxData;
            exp_idx++;
            nrx++;
            dcnt = $urandom_range(max_d, min_d);
        end else if (XMitGo) begin
            check("data_stable", TxData, held);
        end
        prev_go = XMitGo;
        if (txs == 0) begin
            if (XMitGo) begin
                if (dcnt == 0) begin
                    TxEmpty = 1'b0;
                    txs = 1;
                    bcnt = ideal ? 1 : $urandom_range(max_b, 1);
                end else begin
                    dcnt--;
                end
            end
        end else begin
            bcnt--;
            if (bcnt == 0) begin
                TxEmpty = 1'b1;
                txs = 0;
            end
        end
    endtask

    task automatic run(input int nbytes, input int min_d, input int max_d, input int max_b,
                       input bit ideal);
        int budget;
        int target;
        budget = 2000;
        target = nrx + nbytes;
        while (nrx < target && budget > 0) begin
            step(min_d, max_d, max_b, ideal);
            budget--;
        end
        check("timeout", nrx, target);
    endtask

    task automatic apply_reset(input int cycles);
        @(negedge Enable);
        Reset = 1'b0;
        TxEmpty = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(negedge Enable);
            check("rst_go", XMitGo, 1'b0);
            check("rst_data", TxData, 8'h00);
        end
        txs = 0; dcnt = 0; bcnt = 0; cyc = 0; last_rise = 0;
        exp_idx = 0; nrx = 0; prev_go = 1'b0; held = 8'h00;
        Reset = 1'b1;
    endtask

    initial begin
        // reset held with the transmitter ready: no request may escape
        apply_reset(10);

        // ideal transmitter, exact 2-clock cadence
        run(13, 0, 0, 1, 1'b1);
        check("last_rise_cycle", last_rise, 25);
`ifdef TXDRIVER_REPEAT_EN
        run(13, 0, 0, 1, 1'b1);
        check("repeat_count", exp_idx, 26);
`else
        step(0, 0, 1, 1'b1);
        for (int i = 0; i < 22; i++) begin
            step(0, 0, 1, 1'b1);
            check("done_go", XMitGo, 1'b0);
            check("done_data", TxData, 8'h21);
        end
        check("done_count", nrx, 13);
`endif

        // transmitter holds TxEmpty high for 5 clocks after each request
        apply_reset(2);
        run(3, 5, 5, 2, 1'b0);

        // random accept and busy latencies over a whole message
        apply_reset(2);
        run(13, 0, 3, 4, 1'b0);

        // asynchronous reset mid-clock while sending character 6
        apply_reset(2);
        run(6, 1, 3, 3, 1'b0);
        check("pre_rst_go", XMitGo, 1'b1);
        #2;
        Reset = 1'b0;
        #1;
        check("async_go", XMitGo, 1'b0);
        check("async_data", TxData, 8'h00);
        apply_reset(3);
        run(2, 0, 2, 3, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
